// File: rtl/demux_1_4_tdm.sv
// 1:4 time-division demultiplexer: tracks the slot index from a frame-sync marker
// and presents each complete four-word frame on Y with a one-cycle frame_valid pulse.
module demux_1_4_tdm #(
    parameter int unsigned W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     din,
    input  logic             din_valid,
    input  logic             frame_sync,
    output logic [4*W-1:0]   Y,
    output logic [1:0]       s,
    output logic             frame_valid,
    output logic             locked,
    output logic             sync_err
);

    typedef enum logic {
        StHunt,
        StLocked
    } state_e;

    state_e       state;
    logic [W-1:0] sh0;
    logic [W-1:0] sh1;
    logic [W-1:0] sh2;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StHunt;
            s           <= 2'd0;
            sh0         <= '0;
            sh1         <= '0;
            sh2         <= '0;
            Y           <= '0;
            frame_valid <= 1'b0;
            locked      <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
            if (din_valid) begin
                unique case (state)
                    StHunt: begin
                        // Non-sync words are silently dropped until a sync word arrives.
                        if (frame_sync) begin
                            sh0    <= din;
                            s      <= 2'd1;
                            state  <= StLocked;
                            locked <= 1'b1;
                        end
                    end
                    StLocked: begin
                        if (frame_sync && (s != 2'd0)) begin
                            // Early sync: restart the frame on this word.
                            sync_err <= 1'b1;
                            sh0      <= din;
                            s        <= 2'd1;
                        end else if (!frame_sync && (s == 2'd0)) begin
                            sync_err <= 1'b1;
                            state    <= StHunt;
                            locked   <= 1'b0;
                        end else begin
                            unique case (s)
                                2'd0: begin
                                    sh0 <= din;
                                    s   <= 2'd1;
                                end
                                2'd1: begin
                                    sh1 <= din;
                                    s   <= 2'd2;
                                end
                                2'd2: begin
                                    sh2 <= din;
                                    s   <= 2'd3;
                                end
                                default: begin
                                    Y           <= {din, sh2, sh1, sh0};
                                    frame_valid <= 1'b1;
                                    s           <= 2'd0;
                                end
                            endcase
                        end
                    end
                    default: begin
                        state  <= StHunt;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux_1_4_tdm.sv
// Bench for demux_1_4_tdm (W=1): directed vector table followed by randomized
// traffic checked against a queue-based frame-assembly model.
module tb_demux_1_4_tdm;

    logic       clk;
    logic       rst;
    logic [0:0] din;
    logic       din_valid;
    logic       frame_sync;
    logic [3:0] Y;
    logic [1:0] s;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;

    int n_pass  = 0;
    int n_total = 0;

    demux_1_4_tdm #(.W(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .Y          (Y),
        .s          (s),
        .frame_valid(frame_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       v;
        logic       fs;
        logic       d;
        logic [3:0] y;
        logic [1:0] es;
        logic       fv;
        logic       lk;
        logic       er;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, v, fs, d, input logic [3:0] y, input logic [1:0] es,
                       input logic fv, lk, er);
        vec_t t;
        t.r = r; t.v = v; t.fs = fs; t.d = d;
        t.y = y; t.es = es; t.fv = fv; t.lk = lk; t.er = er;
        vecs.push_back(t);
    endtask

    task automatic drive(input logic r, v, fs, d);
        rst        = r;
        din_valid  = v;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] ey, input logic [1:0] es,
                         input logic efv, elk, eer);
        n_total++;
        if ({Y, s, frame_valid, locked, sync_err} === {ey, es, efv, elk, eer}) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got Y=%b s=%0d fv=%b lk=%b err=%b, want Y=%b s=%0d fv=%b lk=%b err=%b",
                     name, Y, s, frame_valid, locked, sync_err, ey, es, efv, elk, eer);
        end
    endtask

    // Reference model: a frame is a queue of collected words; the slot index is its length.
    logic       m_q[$];
    bit         m_locked;
    logic [3:0] m_y;
    bit         m_fv;
    bit         m_err;

    task automatic model_step(input logic r, v, fs, d);
        m_fv  = 0;
        m_err = 0;
        if (r) begin
            m_q.delete();
            m_locked = 0;
            m_y      = 4'b0;
        end else if (v) begin
            if (!m_locked) begin
                if (fs) begin
                    m_q      = {d};
                    m_locked = 1;
                end
            end else if (fs) begin
                if (m_q.size() != 0) m_err = 1;
                m_q = {d};
            end else if (m_q.size() == 0) begin
                m_err    = 1;
                m_locked = 0;
            end else begin
                m_q.push_back(d);
                if (m_q.size() == 4) begin
                    for (int i = 0; i < 4; i++) m_y[i] = m_q[i];
                    m_fv = 1;
                    m_q.delete();
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; din_valid = 1'b0; frame_sync = 1'b0; din = 1'b0;

        // Reset
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        add(1, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
        // Case 1: slots 1,0,1,1
        add(0, 1, 1, 1, 4'b0000, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0000, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0000, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 0, 1, 1, 0);
        // Case 2: one-hot sweep
        add(0, 1, 1, 1, 4'b1101, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1101, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1101, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0001, 0, 1, 1, 0);
        add(0, 1, 1, 0, 4'b0001, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0001, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0001, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0010, 0, 1, 1, 0);
        add(0, 1, 1, 0, 4'b0010, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0010, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0010, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 0, 1, 1, 0);
        add(0, 1, 1, 0, 4'b0100, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1000, 0, 1, 1, 0);
        // Case 3: valid gap between slots 1 and 2
        add(0, 1, 1, 1, 4'b1000, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1000, 2, 0, 1, 0);
        add(0, 0, 1, 1, 4'b1000, 2, 0, 1, 0);
        add(0, 0, 0, 0, 4'b1000, 2, 0, 1, 0);
        add(0, 0, 1, 0, 4'b1000, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1000, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 0, 1, 1, 0);
        // Case 4: early sync on the third word
        add(0, 1, 1, 0, 4'b1101, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 2, 0, 1, 0);
        add(0, 1, 1, 1, 4'b1101, 1, 0, 1, 1);
        add(0, 1, 0, 0, 4'b1101, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0101, 0, 1, 1, 0);
        // Case 5: good frame, missing sync, hunt, relock
        add(0, 1, 1, 1, 4'b0101, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0101, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0101, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 0, 1, 1, 0);
        add(0, 1, 0, 0, 4'b1111, 0, 0, 0, 1);
        add(0, 1, 0, 1, 4'b1111, 0, 0, 0, 0);
        add(0, 1, 0, 0, 4'b1111, 0, 0, 0, 0);
        add(0, 1, 1, 0, 4'b1111, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b1111, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1111, 3, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 0, 1, 1, 0);
        // Case 6: reset mid-frame overrides a valid sync word
        add(0, 1, 1, 1, 4'b0100, 1, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0100, 2, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0100, 3, 0, 1, 0);
        add(1, 1, 1, 1, 4'b0000, 0, 0, 0, 0);
        add(0, 1, 1, 1, 4'b0000, 1, 0, 1, 0);
        add(0, 1, 0, 0, 4'b0000, 2, 0, 1, 0);
        add(0, 1, 0, 1, 4'b0000, 3, 0, 1, 0);
        add(0, 1, 0, 1, 4'b1101, 0, 1, 1, 0);
        add(0, 0, 0, 0, 4'b1101, 0, 0, 1, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].r, vecs[i].v, vecs[i].fs, vecs[i].d);
            check($sformatf("vec%0d", i), vecs[i].y, vecs[i].es, vecs[i].fv, vecs[i].lk,
                  vecs[i].er);
        end

        // Randomized traffic against the frame-assembly model
        drive(1, 0, 0, 0);
        model_step(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, v, fs, d;
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            // Mostly well-formed framing, with occasional misplaced or missing syncs.
            if (m_q.size() == 0) fs = ($urandom_range(0, 9) != 0);
            else                 fs = ($urandom_range(0, 19) == 0);
            d  = $urandom_range(0, 1);
            drive(r, v, fs, d);
            model_step(r, v, fs, d);
            check($sformatf("rand%0d", i), m_y, 2'(m_q.size()), m_fv, m_locked, m_err);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
